// File: rtl/modbus_rtu_frame_rx.sv
// modbus_rtu_frame_rx: oversampled 8N1 MODBUS RTU receiver with t1.5/t3.5 timing, CRC-16 and address filter
module modbus_rtu_frame_rx #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int MAX_BYTES    = 16,
  parameter int T15_BITS     = 17,
  parameter int T35_BITS     = 39,
  parameter bit FILTER_EN    = 1'b1,
  parameter int IDX_W        = 4
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             uart_rx,
  input  logic [7:0]       slave_addr,
  output logic             frame_valid,
  output logic [IDX_W:0]   frame_len,
  output logic [3:0]       frame_err,
  input  logic             frame_ack,
  output logic             frame_dropped,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data,
  output logic             rx_busy
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int SIL_W = $clog2(T35_BITS * CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_M  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [SIL_W-1:0] T15_L  = SIL_W'(T15_BITS * CLKS_PER_BIT);
  localparam logic [SIL_W-1:0] T35_M  = SIL_W'(T35_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W:0]   MAX_L  = (IDX_W + 1)'(MAX_BYTES);
  localparam logic [IDX_W:0]   MIN_L  = (IDX_W + 1)'(4);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bst_t;
  typedef enum logic [1:0] {F_IDLE, F_RECV, F_HOLD, F_DROP} fst_t;

  bst_t             b_q, b_d;
  fst_t             f_q, f_d;
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d, addr_q, rd_q;
  logic [SIL_W-1:0] sil_q, sil_d;
  logic [IDX_W:0]   wr_q, len_q;
  logic [15:0]      crc_q;
  logic [3:0]       err_q;
  logic             act_q, gap_q, fe_q, ov_q;
  logic             rx, fall, stb, eof, gap_set, wr_en, keep, dropped;
  logic [7:0]       mem_q [MAX_BYTES];

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 16'hA001 : r >> 1;
    return r;
  endfunction

  // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection
  assign rx      = sync_q[1];
  assign fall    = sync_q[2] & ~sync_q[1];
  assign sil_d   = (b_q != B_IDLE) ? '0 : (sil_q > T35_M) ? sil_q : sil_q + 1'b1;
  assign eof     = act_q && b_q == B_IDLE && sil_q == T35_M;
  assign gap_set = act_q && b_q == B_IDLE && fall && sil_q > T15_L;
  assign wr_en   = stb && (f_q == F_IDLE || f_q == F_RECV);
  assign keep    = wr_q >= MIN_L && (!FILTER_EN || addr_q == slave_addr || addr_q == 8'h00);

  always_comb begin
    b_d   = b_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d  = sh_q;
    stb   = 1'b0;
    case (b_q)
      B_IDLE: begin
        cnt_d = '0;
        b_d   = fall ? B_START : B_IDLE;
      end
      B_START: if (cnt_q == HALF_M) begin
        cnt_d = '0;
        b_d   = rx ? B_IDLE : B_DATA;
      end
      B_DATA: if (cnt_q == BIT_M) begin
        cnt_d = '0;
        sh_d  = {rx, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        b_d   = (bit_q == 3'd7) ? B_STOP : B_DATA;
      end
      default: if (cnt_q == BIT_M) begin
        cnt_d = '0;
        stb   = 1'b1;
        b_d   = B_IDLE;
      end
    endcase
  end

  always_comb begin
    f_d     = f_q;
    dropped = 1'b0;
    case (f_q)
      F_IDLE: f_d = stb ? F_RECV : F_IDLE;
      F_RECV: if (eof) f_d = keep ? F_HOLD : F_IDLE;
      F_HOLD: begin
        dropped = eof;
        // a frame already under way when released is still discarded whole
        if (frame_ack) f_d = ((act_q || stb) && !eof) ? F_DROP : F_IDLE;
      end
      default: begin
        dropped = eof;
        f_d     = eof ? F_IDLE : F_DROP;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
      b_q    <= B_IDLE;
      f_q    <= F_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      sil_q  <= '0;
      act_q  <= 1'b0;
      wr_q   <= '0;
      crc_q  <= 16'hFFFF;
      gap_q  <= 1'b0;
      fe_q   <= 1'b0;
      ov_q   <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      err_q  <= '0;
      rd_q   <= '0;
    end else begin
      sync_q <= {sync_q[1:0], uart_rx};
      b_q    <= b_d;
      f_q    <= f_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      sil_q  <= sil_d;
      act_q  <= eof ? 1'b0 : act_q | stb;
      wr_q   <= eof ? '0 : (wr_en && wr_q < MAX_L) ? wr_q + 1'b1 : wr_q;
      crc_q  <= eof ? 16'hFFFF : stb ? crc_upd(crc_q, sh_q) : crc_q;
      gap_q  <= eof ? 1'b0 : gap_q | gap_set;
      fe_q   <= eof ? 1'b0 : fe_q | (stb & ~rx);
      ov_q   <= eof ? 1'b0 : ov_q | (wr_en && wr_q >= MAX_L);
      addr_q <= (stb && f_q == F_IDLE) ? sh_q : addr_q;
      len_q  <= (f_q == F_RECV && eof && keep) ? wr_q : len_q;
      err_q  <= (f_q == F_RECV && eof && keep) ? {gap_q, fe_q, ov_q, crc_q != 16'h0000} : err_q;
      rd_q   <= ({1'b0, rd_idx} < len_q) ? mem_q[rd_idx] : 8'h00;
    end
  end

  always_ff @(posedge clk_sys)
    if (rst_n && wr_en && wr_q < MAX_L) mem_q[wr_q[IDX_W-1:0]] <= sh_q;

  assign frame_valid   = f_q == F_HOLD;
  assign frame_len     = len_q;
  assign frame_err     = err_q;
  assign frame_dropped = dropped;
  assign rd_data       = rd_q;
  assign rx_busy       = f_q == F_RECV;
endmodule

// File: doc/modbus_rtu_frame_rx.md
Name: modbus_rtu_frame_rx

Overview:
Parametrised MODBUS RTU receive front-end running entirely on clk_sys. It oversamples uart_rx (8N1, LSB first) with a programmable divider and assembles bytes into a frame buffer. Frame boundaries are delimited by t3.5 silence, with t1.5 inter-character gap checking, on-the-fly CRC-16 (poly 0xA001, init 0xFFFF) and slave-address filtering. The block replaces the fixed-baud, clk_uart-driven receive path in front of the vending command decoder; completed frames are handed over through a valid/ack handshake and an indexed read port.

Parameters:
CLKS_PER_BIT, 2604, clk_sys cycles per bit (50 MHz / 19200).
MAX_BYTES, 16, frame buffer depth in bytes.
T15_BITS, 17, inter-character gap limit in bit periods (1.5 chars × 11 bits).
T35_BITS, 39, end-of-frame silence in bit periods (3.5 chars × 11 bits).
FILTER_EN, 1, 1 = accept only frames addressed to slave_addr or broadcast 0x00; 0 = accept all.
IDX_W, 4, width of rd_idx and frame_len; must satisfy 2^IDX_W ≥ MAX_BYTES.

Ports:
clk_sys  in  1  system clock
rst_n  in  1  synchronous reset, active-low
uart_rx  in  1  serial input, idle high, asynchronous
slave_addr  in  8  own MODBUS address
frame_valid  out  1  held frame available
frame_len  out  IDX_W+1  number of bytes stored (≤ MAX_BYTES)
frame_err  out  4  {gap_err, framing_err, overrun, crc_err}, valid while frame_valid
frame_ack  in  1  consumer releases held frame
frame_dropped  out  1  1-cycle pulse: complete frame discarded because buffer held
rd_idx  in  IDX_W  buffer read index
rd_data  out  8  buffer byte, registered, 1-cycle latency
rx_busy  out  1  frame reception in progress

Behaviour:
- Reset (rst_n=0 at a clk_sys edge): all outputs 0, both FSMs idle, counters and CRC cleared; buffer contents are not cleared. A reset mid-frame abandons the frame; no valid or dropped pulse is produced.
- uart_rx passes through a 2-FF synchroniser before all logic.
- Bit FSM:
  - IDLE: on a falling edge, go to START.
  - START: sample at CLKS_PER_BIT/2; if low, go to DATA, else return to IDLE (glitch).
  - DATA: sample 8 bits, one every CLKS_PER_BIT, LSB first.
  - STOP: sample one CLKS_PER_BIT later. A 0 sets framing_err; the byte is still stored. Return to IDLE.
  - The byte strobe fires on the stop-sample cycle.
- Byte strobe:
  - If wr_ptr < MAX_BYTES: write buffer[wr_ptr], increment wr_ptr.
  - Otherwise set overrun and discard the byte.
  - CRC updates for every received byte, including overrun bytes.
- Silence counter:
  - Clears on each byte strobe and whenever the bit FSM is not IDLE.
  - If a new start bit begins with counter > T15_BITS*CLKS_PER_BIT inside a frame, set gap_err.
  - When the counter reaches T35_BITS*CLKS_PER_BIT with wr_ptr > 0, end the frame.
- Frame FSM:
  - F_IDLE: the first byte strobe moves to F_RECV (rx_busy=1).
  - F_RECV, at end-of-frame:
    - Byte count < 4: runt; discard and return to F_IDLE.
    - FILTER_EN=1 and buffer[0] ∉ {slave_addr, 0x00}: discard and return to F_IDLE, no pulse.
    - Otherwise set crc_err = (CRC ≠ 0x0000), latch frame_len and frame_err, go to F_HOLD.
  - frame_valid asserts in F_HOLD, on the cycle after the end-of-frame.
  - F_HOLD: frame_valid=1. frame_ack=1 clears frame_valid on the next edge and returns to F_IDLE.
- Frames arriving during F_HOLD: deserialised but not written, and buffer/len/err stay stable. At their end-of-frame, pulse frame_dropped for one cycle.
- ack during a new frame: if frame_ack coincides with a byte strobe of a new frame, that frame is dropped. Reception resumes at the next silence.
- rd_data = buffer[rd_idx] one cycle after rd_idx is presented; rd_idx ≥ frame_len returns 0x00.
- frame_ack outside F_HOLD is ignored.

Test Plan:
1. CLKS_PER_BIT=16; send 01 03 00 01 00 01 D5 CA, slave_addr=01 → frame_valid ~39×16 cycles after last stop sample, frame_len=8, frame_err=0000, rd_idx 0..7 returns the same bytes.
2. Same frame with last byte CB → frame_valid, crc_err=1 (frame_err=0001). Repeat with byte 5 stop bit forced 0 → framing_err=1.
3. FILTER_EN=1, slave_addr=01: frame to address 05 with valid CRC → no frame_valid, no frame_dropped. Broadcast 00 06 01 00 00 01 + correct CRC → frame_valid, err=0.
4. 20 valid-timed bytes, MAX_BYTES=16 → frame_len=16, overrun=1, bytes 0..15 intact, rd_idx beyond range → 0x00.
5. Hold frame 1 with no ack, send frame 2 → frame_dropped 1-cycle pulse, frame 1 data unchanged. Assert frame_ack → frame_valid=0 next cycle. A third frame is then accepted.
6. 20-bit idle gap between bytes 3 and 4 → gap_err=1. Assert rst_n=0 during byte 5 of another frame → all outputs 0, no valid after release.
